// File: rtl/bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_subtractor_serial
//  Description : Digit-serial N-digit packed-BCD subtractor. Produces |a - b|
//                one digit per clock (LS digit first) through a registered
//                borrow chain, then ten's-complements the result when a < b.
//                Reports sign (neg) and invalid-digit status (err) with a
//                start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_subtractor_serial #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [4*N-1:0] a,
  input  logic [4*N-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] diff,
  output logic           neg,
  output logic           err
);

  // Digit counter width; a 1-digit build still needs a 1-bit counter.
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [4*N-1:0] a_q, a_d;
  logic [4*N-1:0] b_q, b_d;
  logic [4*N-1:0] res_q, res_d;
  logic [4*N-1:0] diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic           any_bad;
  logic [4:0]     sub_res;
  logic [4:0]     fix_res;
  logic           last_digit;

  // One BCD digit of x - y - bin; returns {borrow_out, digit}.
  // The 5-bit difference spans -10..9, so bit 4 is the sign.
  function automatic logic [4:0] digit_sub(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       bin);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    if (t[4]) begin
      digit_sub = {1'b1, t[3:0] + 4'd10};
    end else begin
      digit_sub = {1'b0, t[3:0]};
    end
  endfunction

  // Flag any operand digit outside 0..9 on the live inputs.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
        any_bad = 1'b1;
      end
    end
  end

  // Per-digit arithmetic for the subtract pass and the complement pass.
  always_comb begin
    sub_res    = digit_sub(a_q[3:0], b_q[3:0], borrow_q);
    fix_res    = digit_sub(4'd0, res_q[3:0], borrow_q);
    last_digit = (idx_q == LAST_IDX);
  end

  // State register and datapath registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    neg_d    = neg_q;
    err_d    = err_q;
    idx_d    = idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (any_bad) begin
            // Invalid operand: report immediately, no arithmetic.
            err_d   = 1'b1;
            diff_d  = '0;
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            a_d      = a;
            b_d      = b;
            err_d    = 1'b0;
            borrow_d = 1'b0;
            idx_d    = '0;
            state_d  = S_SUB;
          end
        end
      end

      S_SUB: begin
        // New digit enters at the MS end so after N shifts digit 0 sits at LSB.
        res_d             = res_q >> 4;
        res_d[4*N-1 -: 4] = sub_res[3:0];
        a_d               = a_q >> 4;
        b_d               = b_q >> 4;
        borrow_d          = sub_res[4];
        idx_d             = idx_q + 1'b1;
        if (last_digit) begin
          idx_d = '0;
          if (sub_res[4]) begin
            // Result is the ten's complement of the magnitude; fix it up.
            neg_d    = 1'b1;
            borrow_d = 1'b0;
            state_d  = S_FIX;
          end else begin
            neg_d   = 1'b0;
            diff_d  = res_d;
            state_d = S_DONE;
          end
        end
      end

      S_FIX: begin
        // Replace each digit by 0 - d - borrow; the final borrow is dropped.
        res_d             = res_q >> 4;
        res_d[4*N-1 -: 4] = fix_res[3:0];
        borrow_d          = fix_res[4];
        idx_d             = idx_q + 1'b1;
        if (last_digit) begin
          idx_d   = '0;
          diff_d  = res_d;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decode directly from the registered state.
  always_comb begin
    busy = (state_q == S_SUB) || (state_q == S_FIX);
    done = (state_q == S_DONE);
    diff = diff_q;
    neg  = neg_q;
    err  = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_subtractor_serial
//  Description : Scoreboard bench for bcd_subtractor_serial with a decimal
//                reference model, directed boundary cases and random vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_subtractor_serial;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         neg;
  logic         err;

  bcd_subtractor_serial #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .neg     (neg),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] diff;
    logic         neg;
    logic         err;
    int           lat;
    int           issue;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model (plain decimal arithmetic) -------------
  function automatic bit bcd_ok(input logic [W-1:0] v);
    bit ok = 1'b1;
    for (int i = 0; i < N; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input int issue);
    exp_t e;
    int   va, vb;
    e.issue = issue;
    if (!bcd_ok(xa) || !bcd_ok(xb)) begin
      e.diff = '0; e.neg = 1'b0; e.err = 1'b1; e.lat = 1;
    end else begin
      va = bcd2int(xa);
      vb = bcd2int(xb);
      e.err  = 1'b0;
      e.neg  = (va < vb);
      e.diff = int2bcd(va >= vb ? va - vb : vb - va);
      e.lat  = (va >= vb) ? N + 1 : 2 * N + 1;
    end
    return e;
  endfunction

  // ---------------- monitor: pops the scoreboard on every done ------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busy_cnt = 0;
    end else if (done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("diff", 64'(diff), 64'(e.diff));
        check("neg", 64'(neg), 64'(e.neg));
        check("err", 64'(err), 64'(e.err));
        check("latency", 64'(cyc - e.issue), 64'(e.lat));
        check("busy_cycles", 64'(busy_cnt), 64'(e.lat - 1));
        check("busy_in_done", 64'(busy), 64'd0);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done; returns one cycle later (the IDLE cycle).
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * N + 8 && !seen; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", 4 * N + 8);
    end
  endtask

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb);
    a = xa;
    b = xb;
    start = 1'b1;
    q.push_back(model(xa, xb, cyc));
    tick();
    start = 1'b0;
    a = $urandom();
    b = $urandom();
    wait_done();
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ---------------- main stimulus ------------------------------------------
  initial begin
    logic [W-1:0] ra, rb;

    reset_n = 1'b0;
    tick(); tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_diff", 64'(diff), 64'd0);
    check("rst_neg", 64'(neg), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset_n = 1'b1;
    tick();

    // Directed cases.
    op(16'h5123, 16'h1234);
    op(16'h1234, 16'h5123);
    op(16'h0000, 16'h0001);
    op(16'h9999, 16'h9999);
    op(16'h9999, 16'h0000);
    op(16'h12A4, 16'h0001);
    op(16'h0010, 16'h0001);

    // Second start during SUB cycle 2 must be dropped.
    a = 16'h5123; b = 16'h1234; start = 1'b1;
    q.push_back(model(16'h5123, 16'h1234, cyc));
    tick();               // capture edge -> SUB cycle 1
    start = 1'b0;
    tick();               // SUB cycle 2
    a = 16'h0000; b = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    repeat (3 * N + 4) tick();
    check("idle_after_ignored_start", 64'(busy), 64'd0);

    // Reset during FIX cycle 2 aborts with no done pulse.
    a = 16'h1234; b = 16'h5123; start = 1'b1;
    tick();               // SUB1
    start = 1'b0;
    repeat (5) tick();    // SUB2..SUB4, FIX1, FIX2
    check("in_fix_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_diff", 64'(diff), 64'd0);
    check("abort_neg", 64'(neg), 64'd0);
    reset_n = 1'b1;
    repeat (2 * N + 6) tick();

    // Random vectors, back to back at the minimum repeat interval.
    for (int k = 0; k < 1000; k++) begin
      ra = rand_bcd();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand_bcd();
      if ($urandom_range(0, 19) == 0) begin
        int p;
        p = $urandom_range(0, N - 1);
        ra[4*p +: 4] = 4'($urandom_range(10, 15));
      end
      op(ra, rb);
    end

    repeat (4) tick();
    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bcd_subtractor_serial.md
Name: bcd_subtractor_serial

Overview:
Digit-serial N-digit packed-BCD subtractor. It computes |a - b| one BCD digit per clock, least-significant digit first, using a registered borrow chain. It is the inverse operation of the team's ripple BCD adder datapath and reports sign and invalid-input status. A start/busy/done handshake connects it to the calculator control FSM.

Parameters:
N, 4, number of BCD digits per operand and per result (N >= 1).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  synchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
a  input  4*N  minuend, packed BCD; digit i is a[4i+3:4i].
b  input  4*N  subtrahend, packed BCD.
busy  output  1  high while in SUB or FIX.
done  output  1  one-cycle pulse; result outputs are valid.
diff  output  4*N  magnitude |a - b|, packed BCD.
neg  output  1  1 when a < b.
err  output  1  1 when any digit of a or b captured at start was > 9.

Behaviour:
- Reset (reset_n low at a rising edge): state returns to IDLE; busy, done, neg and err go to 0; diff goes to 0; internal shift registers, borrow and digit counter are cleared. Reset takes priority in every state and aborts any operation in progress; no done pulse is produced.
- States: IDLE, SUB, FIX, DONE.
- IDLE, start=1, all digits valid:
  - Capture a and b into shift registers.
  - Clear err; set borrow=0 and idx=0.
  - Go to SUB.
- IDLE, start=1, any digit of a or b > 9:
  - Set err=1, diff=0, neg=0.
  - Go to DONE; no arithmetic is performed.
- IDLE, start=0: hold; diff, neg and err keep their last values.
- SUB, one digit per cycle:
  - t = a_d - b_d - borrow, computed in 5-bit signed arithmetic.
  - If t < 0: digit = t + 10, borrow = 1. Otherwise: digit = t, borrow = 0.
  - Shift the digit into the result register from the MS end.
  - After digit N-1: if borrow = 1, go to FIX with neg=1; otherwise go to DONE with neg=0.
- FIX, N cycles, ten's complement of the result:
  - Borrow restarts at 0.
  - Each digit d is replaced by (0 - d - borrow) using the same rule as SUB.
  - After N digits, go to DONE.
  - The final borrow of FIX is ignored.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - diff, neg and err are valid in this cycle.
  - Next state is IDLE.
  - diff, neg and err hold until the next accepted start.
- start is ignored in SUB, FIX and DONE. No queuing: a start pulse during these states is lost.
- Latency, counted from the start-sampling edge to the cycle in which done is high:
  - N+1 cycles when a >= b.
  - 2N+1 cycles when a < b.
  - 1 cycle for an invalid input.
- The result is always a valid BCD digit string.
- a == b gives diff=0 and neg=0; negative zero never occurs.
- a and b may change freely after the capture edge.
- Minimum repeat interval: start may be reasserted in the cycle after done. That is the IDLE cycle, and start is accepted there.

Test Plan:
- N=4, a=16'h5123, b=16'h1234, start for 1 cycle -> busy high for 4 cycles; done 5 cycles after start; diff=16'h3889, neg=0, err=0.
- a=16'h1234, b=16'h5123 -> busy high for 8 cycles; done 9 cycles after start; diff=16'h3889, neg=1.
- Boundary cases:
  - a=16'h0000, b=16'h0001 -> diff=16'h0001, neg=1.
  - a=16'h9999, b=16'h9999 -> diff=16'h0000, neg=0.
  - a=16'h9999, b=16'h0000 -> diff=16'h9999, neg=0, latency 5.
- a=16'h12A4, b=16'h0001 -> done in the next cycle; err=1, diff=16'h0000, neg=0.
- Then a valid start with a=16'h0010, b=16'h0001 -> err clears, diff=16'h0009, neg=0.
- Start accepted, then start pulsed again in SUB cycle 2 -> second request ignored; exactly one done pulse with the first result.
- Reset_n low in FIX cycle 2 -> next cycle: IDLE, busy=0, done=0, diff=0, neg=0; no done pulse follows.
- Randomised check (1000 vectors): random valid BCD operands against a decimal reference model; diff, neg and latency all match.
